// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RV32I pipeline.
// Arbitrates branch redirect > load-use stall > halt request and drives the
// fetch enable, PC select, IF/ID enable and the IF/ID and ID/EX flush controls.
// Outputs are Mealy (combinational from state and current inputs) so a branch
// decision in EX redirects the PC on the same rising edge.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the three 32-bit
// performance counters; otherwise the counter ports are tied to zero.
//
// LOAD_LATENCY must be within 1..7 (the bubble counter is 3 bits wide).

module pipeline_hazard_ctrl #(
   parameter int unsigned LOAD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  ex_branch,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        halt_req,
   output logic [1:0]  pc_sel,
   output logic        if_en,
   output logic        id_en,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        halted,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
   output logic [31:0] halt_cycles
);

   // PC_MUX_ENUM value meaning "sequential PC, no redirect"
   localparam logic [1:0] PC_NOP   = 2'd0;
   // bubble count loaded on STALL entry; the RUN cycle that detects the
   // hazard already accounts for one of the LOAD_LATENCY frozen cycles
   localparam logic [2:0] CNT_INIT = 3'(LOAD_LATENCY - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       lu, br;

   assign lu = ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign br = (ex_branch != PC_NOP);

   // next-state and Mealy outputs; reset forces the pipeline into a frozen,
   // fully flushed condition
   always_comb begin
      pc_sel    = PC_NOP;
      if_en     = 1'b1;
      id_en     = 1'b1;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!rst_n) begin
         if_en     = 1'b0;
         id_en     = 1'b0;
         id_flush  = 1'b1;
         ex_flush  = 1'b1;
         state_nxt = RUN;
         cnt_nxt   = 3'd0;
      end else begin
         case (state)
            RUN: begin
               if (br) begin
                  pc_sel   = ex_branch;
                  id_flush = 1'b1;
                  ex_flush = 1'b1;
               end else if (lu) begin
                  if_en    = 1'b0;
                  id_en    = 1'b0;
                  ex_flush = 1'b1;
                  if (LOAD_LATENCY > 1) begin
                     state_nxt = STALL;
                     cnt_nxt   = CNT_INIT;
                  end
               end else if (halt_req) begin
                  if_en     = 1'b0;
                  id_en     = 1'b0;
                  ex_flush  = 1'b1;
                  state_nxt = HALT;
               end
            end
            STALL: begin
               // EX holds a bubble here, so branch/hazard/halt inputs are stale
               if_en    = 1'b0;
               id_en    = 1'b0;
               ex_flush = 1'b1;
               cnt_nxt  = cnt - 3'd1;
               if (cnt <= 3'd1)
                  state_nxt = RUN;
            end
            HALT: begin
               if (halt_req) begin
                  if_en    = 1'b0;
                  id_en    = 1'b0;
                  ex_flush = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   assign halted = rst_n && (state == HALT);

   // FSM state and bubble counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q, flush_q, halt_q;

   // performance counters, free-running and wrapping at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
         halt_q  <= 32'd0;
      end else begin
         if (!if_en && (state != HALT))
            stall_q <= stall_q + 32'd1;
         if ((state == RUN) && br)
            flush_q <= flush_q + 32'd1;
         if (state == HALT)
            halt_q <= halt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
   assign halt_cycles  = halt_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_events = 32'd0;
   assign halt_cycles  = 32'd0;
`endif

endmodule
